// File: rtl/bus_trace_buffer_if.sv
// Trace buffer bus: traced CPU signals, capture control and readout.
interface bus_trace_buffer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4
);
    localparam int EW = 1 + 3 * ADDR_WIDTH + DATA_WIDTH;

    logic                  sample_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] sp;
    logic                  arm;
    logic [1:0]            trig_mode;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic                  rd_en;
    logic [EW-1:0]         rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2-1:0] trig_idx;
    logic [1:0]            state;

    modport master (
        output sample_en, mem_we, mem_addr, mem_data, pc, sp,
        output arm, trig_mode, trig_addr, rd_en,
        input  rd_data, rd_valid, empty, count, trig_idx, state
    );

    modport slave (
        input  sample_en, mem_we, mem_addr, mem_data, pc, sp,
        input  arm, trig_mode, trig_addr, rd_en,
        output rd_data, rd_valid, empty, count, trig_idx, state
    );
endinterface

// File: rtl/bus_trace_buffer.sv
// Circular capture buffer for the CPU bus with trigger, post-trigger
// window and oldest-first readout.
module bus_trace_buffer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int POST_TRIG  = 8
) (
    input logic               clk,
    input logic               rst_n,
    bus_trace_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int EW    = 1 + 3 * ADDR_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (POST_TRIG > DEPTH - 1) begin : g_bad_post_trig
        $error("POST_TRIG must not exceed 2**DEPTH_LOG2-1");
    end

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
    logic [DEPTH_LOG2-1:0] trig_idx_q, trig_idx_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [EW-1:0]         rd_data_q, rd_data_d;
    logic [EW-1:0]         ram_q [DEPTH];

    logic [EW-1:0]         entry;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_en;
    logic                  hit;

    assign entry = {bus.mem_we, bus.mem_addr, bus.mem_data,
                    bus.pc, bus.sp};

    // wr_ptr is frozen in DONE, so shrinking count walks rd_ptr forward.
    assign rd_ptr = wr_ptr_q - count_q[DEPTH_LOG2-1:0];

    always_comb begin
        hit = 1'b0;
        unique case (bus.trig_mode)
            2'd0:    hit = 1'b1;
            2'd1:    hit = bus.mem_we && (bus.mem_addr == bus.trig_addr);
            2'd2:    hit = (bus.pc == bus.trig_addr);
            default: hit = bus.mem_we;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        trig_idx_d = trig_idx_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;
        if (bus.arm) begin
            state_d    = S_ARMED;
            wr_en      = bus.sample_en;
            wr_addr    = '0;
            wr_ptr_d   = {{(DEPTH_LOG2-1){1'b0}}, bus.sample_en};
            count_d    = {{DEPTH_LOG2{1'b0}}, bus.sample_en};
            post_cnt_d = '0;
        end else begin
            unique case (1'b1)
                state_q == S_ARMED: begin
                    if (bus.sample_en) begin
                        wr_en = 1'b1;
                        if (hit) begin
                            post_cnt_d = DEPTH_LOG2'(POST_TRIG);
                            state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                        end
                    end
                end
                state_q == S_POST: begin
                    if (bus.sample_en) begin
                        wr_en      = 1'b1;
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == DEPTH_LOG2'(1)) state_d = S_DONE;
                    end
                end
                state_q == S_DONE: begin
                    if (bus.rd_en && count_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = ram_q[rd_ptr];
                        count_d    = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = (count_q == FULL) ? count_q : count_q + 1'b1;
            end
        end
        if (state_d == S_DONE && state_q != S_DONE)
            trig_idx_d = DEPTH_LOG2'(count_d - CW'(POST_TRIG + 1));
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram_q[wr_addr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            trig_idx_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            trig_idx_q <= trig_idx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.empty    = (count_q == '0);
    assign bus.trig_idx = trig_idx_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer with a queue-based reference
// model checked every cycle.
module tb_bus_trace_buffer;
    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DL    = 4;
    localparam int PT    = 8;
    localparam int DEPTH = 16;
    localparam int EW    = 1 + 3 * AW + DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int vectors     = 0;
    int miscompares = 0;

    bus_trace_buffer_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)
    ) bus ();

    bus_trace_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .DEPTH_LOG2(DL), .POST_TRIG(PT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference: everything captured since arm, frozen into a read queue.
    logic [EW-1:0] cap[$];
    logic [EW-1:0] rdq[$];
    int            m_phase = 0;
    int            m_left  = 0;
    int            m_trig  = 0;
    int            m_tidx  = 0;
    logic          m_rv    = 1'b0;
    logic [EW-1:0] m_rd    = '0;

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int m_count();
        if (m_phase == 3) return rdq.size();
        if (m_phase == 0) return 0;
        return (cap.size() > DEPTH) ? DEPTH : cap.size();
    endfunction

    function automatic bit m_hit();
        case (bus.trig_mode)
            2'd0:    return 1'b1;
            2'd1:    return bus.mem_we && bus.mem_addr == bus.trig_addr;
            2'd2:    return bus.pc == bus.trig_addr;
            default: return bus.mem_we;
        endcase
    endfunction

    function automatic void m_freeze();
        int n, k;
        n = cap.size();
        k = (n > DEPTH) ? DEPTH : n;
        rdq.delete();
        for (int i = n - k; i < n; i++) rdq.push_back(cap[i]);
        m_tidx = m_trig - 1 - (n - k);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cap.delete();
            rdq.delete();
            m_phase = 0;
            m_rv    = 1'b0;
            m_rd    = '0;
            m_tidx  = 0;
        end else begin
            logic [EW-1:0] e;
            e = {bus.mem_we, bus.mem_addr, bus.mem_data, bus.pc, bus.sp};
            m_rv = 1'b0;
            if (bus.arm) begin
                cap.delete();
                rdq.delete();
                m_phase = 1;
                if (bus.sample_en) cap.push_back(e);
            end else if (m_phase == 1 && bus.sample_en) begin
                cap.push_back(e);
                if (m_hit()) begin
                    m_trig  = cap.size();
                    m_left  = PT;
                    m_phase = (PT == 0) ? 3 : 2;
                    if (m_phase == 3) m_freeze();
                end
            end else if (m_phase == 2 && bus.sample_en) begin
                cap.push_back(e);
                m_left--;
                if (m_left == 0) begin
                    m_phase = 3;
                    m_freeze();
                end
            end else if (m_phase == 3 && bus.rd_en && rdq.size() > 0) begin
                m_rd = rdq.pop_front();
                m_rv = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("state", 64'(bus.state), 64'(m_phase));
        chk("count", 64'(bus.count), 64'(m_count()));
        chk("empty", 64'(bus.empty), 64'(m_count() == 0));
        chk("rd_valid", 64'(bus.rd_valid), 64'(m_rv));
        if (m_rv) chk("rd_data", 64'(bus.rd_data), 64'(m_rd));
        if (m_phase == 3) chk("trig_idx", 64'(bus.trig_idx), 64'(m_tidx));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [AW-1:0] pc_of(input logic [EW-1:0] e);
        return e[2*AW-1:AW];
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [EW-1:0] e);
        return e[EW-2 -: AW];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.sample_en = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.pc        = '0;
        bus.sp        = '0;
        bus.arm       = 1'b0;
        bus.trig_mode = 2'd0;
        bus.trig_addr = '0;
        bus.rd_en     = 1'b0;
    endtask

    task automatic smp(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [AW-1:0] p,
                       input logic [AW-1:0] s);
        bus.sample_en = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = a;
        bus.mem_data  = d;
        bus.pc        = p;
        bus.sp        = s;
        bus.arm       = 1'b0;
        bus.rd_en     = 1'b0;
        tick();
        bus.sample_en = 1'b0;
    endtask

    task automatic arm_pulse(input logic [1:0] mode,
                             input logic [AW-1:0] ta, input logic se);
        bus.trig_mode = mode;
        bus.trig_addr = ta;
        bus.arm       = 1'b1;
        bus.sample_en = se;
        bus.rd_en     = 1'b0;
        tick();
        bus.arm       = 1'b0;
        bus.sample_en = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en     = 1'b1;
        bus.sample_en = 1'b0;
        bus.arm       = 1'b0;
        tick();
        bus.rd_en     = 1'b0;
    endtask

    task automatic async_rst(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_state"}, 64'(bus.state), 0);
        chk({tag, "_count"}, 64'(bus.count), 0);
        chk({tag, "_empty"}, 64'(bus.empty), 1);
        chk({tag, "_rv"}, 64'(bus.rd_valid), 0);
        clr_in();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int p;
        clr_in();
        tick();
        tick();
        chk("rst_state", 64'(bus.state), 0);
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_empty", 64'(bus.empty), 1);
        chk("rst_rv", 64'(bus.rd_valid), 0);
        chk("rst_rdata", 64'(bus.rd_data), 0);
        chk("rst_tidx", 64'(bus.trig_idx), 0);
        rst_n = 1'b1;
        tick();

        arm_pulse(2'd0, '0, 1'b0);
        for (int i = 1; i <= 3; i++)
            smp(1'b0, AW'(i), DW'(i), AW'(i), AW'(i));
        chk("t1_post", 64'(bus.state), 2);
        async_rst("t1");

        arm_pulse(2'd0, '0, 1'b0);
        for (int i = 1; i <= 20; i++)
            smp(1'b0, AW'(i), DW'(16'hA000 + i), AW'(i), AW'(63 - i));
        chk("t2_state", 64'(bus.state), 3);
        chk("t2_count", 64'(bus.count), 9);
        chk("t2_tidx", 64'(bus.trig_idx), 0);
        for (int k = 0; k < 9; k++) begin
            pop();
            chk("t2_rv", 64'(bus.rd_valid), 1);
            chk("t2_pc", 64'(pc_of(bus.rd_data)), 64'(k + 1));
        end
        chk("t2_empty", 64'(bus.empty), 1);

        arm_pulse(2'd1, 6'h10, 1'b0);
        for (int i = 1; i <= 30; i++)
            smp(i[0], AW'(i), DW'(i), AW'(i), '0);
        smp(1'b1, 6'h10, 16'hBEEF, AW'(31), '0);
        for (int i = 32; i <= 39; i++)
            smp(1'b0, AW'(i), DW'(i), AW'(i), '0);
        chk("t3_state", 64'(bus.state), 3);
        chk("t3_count", 64'(bus.count), 16);
        chk("t3_tidx", 64'(bus.trig_idx), 7);
        for (int k = 0; k < 16; k++) begin
            pop();
            chk("t3_pc", 64'(pc_of(bus.rd_data)), 64'(24 + k));
            if (k == 7) begin
                chk("t3_trig_we", 64'(bus.rd_data[EW-1]), 1);
                chk("t3_trig_addr", 64'(addr_of(bus.rd_data)), 64'h10);
            end
        end
        chk("t3_empty", 64'(bus.empty), 1);
        pop();
        chk("t3_rv_empty", 64'(bus.rd_valid), 0);

        arm_pulse(2'd2, 6'h05, 1'b0);
        p = 1;
        for (int j = 0; j < 40; j++) begin
            if (j[0] == 1'b0) begin
                smp(1'b0, '0, DW'(j), AW'(p), '0);
                p++;
            end else begin
                bus.sample_en = 1'b0;
                bus.pc        = 6'h05;
                tick();
            end
        end
        chk("t4_count", 64'(bus.count), 13);
        chk("t4_tidx", 64'(bus.trig_idx), 4);
        for (int k = 0; k < 13; k++) begin
            pop();
            chk("t4_pc", 64'(pc_of(bus.rd_data)), 64'(k + 1));
        end

        arm_pulse(2'd0, '0, 1'b0);
        for (int i = 1; i <= 6; i++)
            smp(1'b0, AW'(i), DW'(i), AW'(i), '0);
        chk("t5_post", 64'(bus.state), 2);
        arm_pulse(2'd1, 6'h10, 1'b0);
        chk("t5_state", 64'(bus.state), 1);
        chk("t5_count", 64'(bus.count), 0);
        for (int i = 1; i <= 20; i++)
            smp(1'b0, AW'(i), DW'(i), AW'(i), '0);
        smp(1'b1, 6'h10, 16'h1234, AW'(21), '0);
        for (int i = 22; i <= 29; i++)
            smp(1'b0, AW'(i), DW'(i), AW'(i), '0);
        chk("t5_done", 64'(bus.state), 3);
        chk("t5_full", 64'(bus.count), 16);
        chk("t5_tidx", 64'(bus.trig_idx), 7);
        pop();
        chk("t5_first", 64'(pc_of(bus.rd_data)), 14);

        bus.mem_we = 1'b1;
        arm_pulse(2'd3, '0, 1'b1);
        chk("t6_state", 64'(bus.state), 1);
        chk("t6_count", 64'(bus.count), 1);
        smp(1'b0, 6'h01, 16'h0001, 6'h01, '0);
        chk("t6_nowr", 64'(bus.state), 1);
        smp(1'b1, 6'h02, 16'h0002, 6'h02, '0);
        chk("t6_trig", 64'(bus.state), 2);
        chk("t6_count3", 64'(bus.count), 3);

        for (int i = 3; i <= 10; i++)
            smp(1'b0, AW'(i), DW'(i), AW'(i), '0);
        chk("t7_count", 64'(bus.count), 11);
        pop();
        chk("t7_rv", 64'(bus.rd_valid), 1);
        async_rst("t7");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
